if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 21 ++
 rtl/if_stage.sv | 126 ++++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches, buffers one word across a
// downstream freeze, and drains an in-flight request when a redirect arrives
// before the memory has answered.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [31:0]        branch_addr,
  if_stage_if.master         imem,
  output logic               fetch_valid,
  output logic [31:0]        instruction,
  output logic [31:0]        pc_out
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic [31:0] pc_inc;
  logic [31:0] br_tgt;
  logic        xfer;

  assign pc_inc = pc_q + 32'd4;
  assign br_tgt = branch_addr & ~32'h3;

  // Next-state logic and combinational fetch outputs.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    imem.imem_req = 1'b0;
    imem.imem_addr = pc_q;
    fetch_valid   = 1'b0;
    instruction   = NOP_INSTR;
    pc_out        = '0;
    xfer          = 1'b0;

    unique case (state_q)
      FETCH: begin
        imem.imem_req = 1'b1;
        xfer          = imem.imem_ready;
        fetch_valid   = imem.imem_ready & ~branch_taken;
        if (fetch_valid) begin
          instruction = imem.imem_rdata;
          pc_out      = pc_inc;
        end
        if (xfer) begin
          if (branch_taken) begin
            pc_d = br_tgt;
          end else begin
            pc_d = pc_inc;
            if (freeze) begin
              buf_instr_d = imem.imem_rdata;
              buf_pc_d    = pc_inc;
              state_d     = HOLD;
            end
          end
        end else if (branch_taken) begin
          tgt_d   = br_tgt;
          state_d = DRAIN;
        end
      end

      HOLD: begin
        fetch_valid = 1'b1;
        instruction = buf_instr_q;
        pc_out      = buf_pc_q;
        if (branch_taken) begin
          pc_d    = br_tgt;
          state_d = FETCH;
        end else if (!freeze) begin
          state_d = FETCH;
        end
      end

      DRAIN: begin
        // Request must stay up at the old address until the memory answers;
        // the returned word is dropped and the latest redirect is applied.
        imem.imem_req = 1'b1;
        xfer          = imem.imem_ready;
        if (branch_taken) tgt_d = br_tgt;
        if (xfer) begin
          pc_d    = branch_taken ? br_tgt : tgt_q;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase

    if (rst) begin
      imem.imem_req = 1'b0;
      fetch_valid   = 1'b0;
      instruction   = NOP_INSTR;
      pc_out        = '0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      tgt_q       <= '0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule
